// File: rtl/pc_seq.sv
// Program-counter sequencer: steps the fetch address, redirects on taken
// branches/jumps with a one-cycle flush bubble, and parks in HALT until reset.
module pc_seq #(
  parameter int unsigned          DATAWIDTH = 32,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = {DATAWIDTH{1'b0}},
  parameter int unsigned          STEP      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ready_i,
  input  logic                 br_valid_i,
  input  logic                 jump_i,
  input  logic                 cond_i,
  input  logic                 neg_i,
  input  logic [DATAWIDTH-1:0] target_i,
  input  logic                 halt_i,
  output logic [DATAWIDTH-1:0] pc_o,
  output logic                 pc_valid_o,
  output logic                 flush_o,
  output logic                 taken_o,
  output logic                 align_err_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [DATAWIDTH-1:0] W_STEP = DATAWIDTH'(STEP);

  state_t               r_state;
  logic [DATAWIDTH-1:0] r_pc;
  logic                 r_pc_valid;
  logic                 r_flush;
  logic                 r_taken;
  logic                 r_align_err;

  state_t               w_next_state;
  logic [DATAWIDTH-1:0] w_next_pc;
  logic                 w_take;
  logic                 w_taken;
  logic                 w_align_err;

  assign w_take = br_valid_i & (jump_i | (cond_i ^ neg_i));

  // Next-state and next-PC selection; branch resolution only matters in RUN.
  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_taken      = 1'b0;
    w_align_err  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (halt_i) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_take) begin
          // A halt in the same cycle still redirects, but lands in HALT.
          w_next_pc    = {target_i[DATAWIDTH-1:2], 2'b00};
          w_taken      = 1'b1;
          w_align_err  = |target_i[1:0];
          w_next_state = halt_i ? S_HALT : S_FLUSH;
        end else if (halt_i) begin
          w_next_state = S_HALT;
        end else if (ready_i) begin
          w_next_pc    = r_pc + W_STEP;
        end else begin
          w_next_pc    = r_pc;
        end
      end
      S_FLUSH: begin
        if (halt_i) begin
          w_next_state = S_HALT;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_HALT: begin
        w_next_state = S_HALT;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; valid is pre-decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_pc_valid  <= 1'b0;
      r_flush     <= 1'b0;
      r_taken     <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_pc_valid  <= (w_next_state == S_RUN);
      r_flush     <= w_taken;
      r_taken     <= w_taken;
      r_align_err <= w_align_err;
    end
  end

  assign pc_o        = r_pc;
  assign pc_valid_o  = r_pc_valid;
  assign flush_o     = r_flush;
  assign taken_o     = r_taken;
  assign align_err_o = r_align_err;

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, PC and target width in bits.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have parameter STEP, default 4, sequential PC increment.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port ready_i  input  1  fetch side accepts the current pc_o this cycle.
REQ-007 SHALL have port br_valid_i  input  1  decode presents a resolved branch/jump this cycle.
REQ-008 SHALL have port jump_i  input  1  unconditional jump qualifier for br_valid_i.
REQ-009 SHALL have port cond_i  input  1  comparator result for the branch (out_o of the cmp block).
REQ-010 SHALL have port neg_i  input  1  invert cond_i (BNE/BLT-style branches).
REQ-011 SHALL have port target_i  input  DATAWIDTH  branch/jump destination.
REQ-012 SHALL have port halt_i  input  1  stop fetching.
REQ-013 SHALL have port pc_o  output  DATAWIDTH  current fetch address.
REQ-014 SHALL have port pc_valid_o  output  1  pc_o is a valid fetch request.
REQ-015 SHALL have port flush_o  output  1  one-cycle pulse: discard in-flight wrong-path fetches.
REQ-016 SHALL have port taken_o  output  1  one-cycle pulse: a branch/jump was taken.
REQ-017 SHALL have port align_err_o  output  1  one-cycle pulse: taken target had nonzero bits [1:0].

Function
REQ-018 SHALL implement states IDLE, RUN, FLUSH, HALT.
REQ-019 SHALL define take = br_valid_i & (jump_i | (cond_i ^ neg_i)).
REQ-020 IDLE SHALL hold pc_o, drive pc_valid_o=0, and go to RUN after exactly one cycle.
REQ-021 RUN SHALL drive pc_valid_o=1.
REQ-022 RUN, take=1: pc_o <= {target_i[DATAWIDTH-1:2],2'b00}; flush_o=1 and taken_o=1 next cycle; state -> FLUSH; ready_i ignored.
REQ-023 RUN, take=1, target_i[1:0]!=0: align_err_o=1 in the same cycle as taken_o; the redirect still happens with the aligned target.
REQ-024 RUN, take=0, ready_i=1: pc_o <= pc_o + STEP, modulo 2^DATAWIDTH (wrap to 0, no error).
REQ-025 RUN, take=0, ready_i=0: pc_o SHALL hold (stall).
REQ-026 FLUSH SHALL drive pc_valid_o=0 for exactly one cycle, hold pc_o, ignore br_valid_i, then go to RUN.
REQ-027 halt_i=1 in IDLE, RUN or FLUSH SHALL move to HALT next cycle; a same-cycle take SHALL still redirect pc_o, but no pc increment SHALL occur.
REQ-028 HALT SHALL drive pc_valid_o=0, hold pc_o, ignore all inputs except rst_i, and leave only via reset.
REQ-029 flush_o, taken_o and align_err_o SHALL be registered, high for exactly one cycle per taken branch, and 0 otherwise.
REQ-030 pc_o and pc_valid_o SHALL be registered outputs; no combinational path from any input to any output.

Reset
REQ-031 rst_i=1 at a clock edge SHALL set pc_o=RESET_PC, pc_valid_o=0, flush_o=0, taken_o=0, align_err_o=0, state IDLE.
REQ-032 Reset SHALL take priority over every other input, including a simultaneous take or halt_i, and SHALL abort a FLUSH or HALT.

Verification
REQ-033 Reset then ready_i=1 held: pc_valid_o=0 for 1 cycle, then pc_o=0,4,8,12 on successive cycles.
REQ-034 pc_o=0x10, br_valid_i=1, cond_i=1, neg_i=0, target_i=0x100: next cycle pc_o=0x100, flush_o=1, taken_o=1, pc_valid_o=0; the following cycle pc_valid_o=1 and pc_o=0x100.
REQ-035 br_valid_i=1, cond_i=1, neg_i=1, jump_i=0, ready_i=0 at pc_o=0x20: no redirect, pc_o stays 0x20, taken_o=0.
REQ-036 DATAWIDTH=32, pc_o=0xFFFFFFFC, ready_i=1: next pc_o=0x00000000, no flags set.
REQ-037 jump_i=1, target_i=0x203: pc_o=0x200, taken_o=1, align_err_o=1 in the same cycle; br_valid_i=1 in the FLUSH cycle is ignored.
REQ-038 halt_i=1 in RUN, then rst_i=1 five cycles later: pc_valid_o=0 throughout HALT; after reset pc_o=RESET_PC and sequencing resumes per REQ-033.
